exp_addr_stage: RTL and testbench

//  Front end of the 64-entry exponent LUT in the softmax exp unit. Accepts a stream of
//  non-positive fixed-point differences (x - max), quantises each to a 6-bit LUT index

---
 rtl/exp_addr_stage.sv | 149 ++++++++++++++
 tb/tb_exp_addr_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_addr_stage.sv
// Softmax exp unit: LUT address front end.
// Quantises (x - max) to a 6-bit index and captures the LUT word.
module exp_addr_stage #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int ADDR_SHIFT = 3,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic [5:0]        lut_addr,
    input  logic [31:0]       lut_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_exp,
    output logic              out_sat,
    output logic              out_last
);

    // The binary point only sets the meaning of one LUT bin; it
    // must still sit inside the word.
    if (FRAC_W > DATA_W) begin : g_bad_frac_w
    end

    logic              stall;
    logic              accept;
    logic              x_pos;
    logic              q_big;
    logic [DATA_W:0]   mag;
    logic [DATA_W:0]   q;
    logic [5:0]        idx;
    logic              idx_sat;
    logic [LEN_W-1:0]  eff_len;
    logic              elem_last;

    logic              s1_valid_q, s1_valid_d;
    logic [5:0]        lut_addr_q, lut_addr_d;
    logic              s1_sat_q, s1_sat_d;
    logic              s1_last_q, s1_last_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_exp_q, out_exp_d;
    logic              out_sat_q, out_sat_d;
    logic              out_last_q, out_last_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = reset_n && !stall;
    assign accept   = in_valid && in_ready;

    // Quantise |x| to a LUT bin, clamping positives and far tails.
    always_comb begin
        mag     = -{in_x[DATA_W-1], in_x};
        q       = mag >> ADDR_SHIFT;
        x_pos   = !in_x[DATA_W-1] && (in_x != '0);
        q_big   = |q[DATA_W:6];
        idx_sat = x_pos || q_big;
        if (x_pos) begin
            idx = 6'd0;
        end else if (q_big) begin
            idx = 6'h3f;
        end else begin
            idx = q[5:0];
        end
    end

    // Element position in the vector; length latched on the first element.
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        eff_len = len_q;
        if (cnt_q == '0) begin
            eff_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        end
        elem_last = (cnt_q == eff_len - LEN_W'(1));
        if (accept) begin
            len_d = eff_len;
            cnt_d = elem_last ? '0 : cnt_q + LEN_W'(1);
        end
    end

    // Stage 1: hold the LUT address while the output is stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        lut_addr_d = lut_addr_q;
        s1_sat_d   = s1_sat_q;
        s1_last_d  = s1_last_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                lut_addr_d = idx;
                s1_sat_d   = idx_sat;
                s1_last_d  = elem_last;
            end
        end
    end

    // Stage 2: capture the LUT word; flags cleared with a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_exp_d   = out_exp_q;
        out_sat_d   = out_sat_q;
        out_last_d  = out_last_q;
        if (!stall) begin
            out_valid_d = s1_valid_q;
            out_exp_d   = lut_exp;
            out_sat_d   = s1_valid_q && s1_sat_q;
            out_last_d  = s1_valid_q && s1_last_q;
        end
    end

    // State update; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            lut_addr_q  <= 6'd0;
            s1_sat_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_exp_q   <= 32'd0;
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
            len_q       <= LEN_W'(1);
        end else begin
            s1_valid_q  <= s1_valid_d;
            lut_addr_q  <= lut_addr_d;
            s1_sat_q    <= s1_sat_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_exp_q   <= out_exp_d;
            out_sat_q   <= out_sat_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
        end
    end

    assign lut_addr  = lut_addr_q;
    assign out_valid = out_valid_q;
    assign out_exp   = out_exp_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_exp_addr_stage.sv
// Bench for exp_addr_stage: vector table, scoreboard and
// hand-written stall / reset / vector-length sequences.
module tb_exp_addr_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  cfg_len = 8'd1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = 16'd0;
    logic [5:0]  lut_addr;
    logic [31:0] lut_exp;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_exp;
    logic        out_sat;
    logic        out_last;

    exp_addr_stage dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .lut_addr (lut_addr),
        .lut_exp  (lut_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_exp  (out_exp),
        .out_sat  (out_sat),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lut_fn(input logic [5:0] a);
        return {16'hC0DE, 2'b01, a, 2'b10, ~a};
    endfunction

    assign lut_exp = lut_fn(lut_addr);

    typedef struct {
        logic [31:0] exp;
        logic        sat;
        logic        last;
    } sb_t;

    typedef struct {
        logic [15:0] x;
        logic [5:0]  idx;
        logic        sat;
    } vec_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mcnt = 0;
    int          mlen = 1;
    int          n_out = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic [15:0] last_mask = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_idx(input logic [15:0] x);
        int xs;
        int q;
        xs = int'($signed(x));
        if (xs > 0) return {1'b1, 6'd0};
        q = (-xs) / 8;
        if (q > 63) return {1'b1, 6'd63};
        return {1'b0, 6'(q)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops on output handshake, pushes on input accept.
    initial forever begin
        logic [6:0] r;
        int         eff;
        logic       lst;
        sb_t        e;
        @(negedge clk);
        if (!reset_n) begin
            sb.delete();
            mcnt = 0;
            mlen = 1;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got %h expected none",
                             out_exp);
                end else begin
                    e = sb.pop_front();
                    chk("sb_exp", out_exp, e.exp);
                    chk("sb_sat", 32'(out_sat), 32'(e.sat));
                    chk("sb_last", 32'(out_last), 32'(e.last));
                end
                if (n_out < 16) last_mask[n_out] = out_last;
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
            if (in_valid && in_ready) begin
                r = ref_idx(in_x);
                if (mcnt == 0) begin
                    eff  = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
                    mlen = eff;
                end else begin
                    eff = mlen;
                end
                lst  = (mcnt == eff - 1);
                mcnt = lst ? 0 : mcnt + 1;
                sb.push_back('{lut_fn(r[5:0]), r[6], lst});
            end
        end
    end

    task automatic send(input logic [15:0] x);
        logic acc;
        int   t;
        t        = 0;
        in_valid = 1'b1;
        in_x     = x;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 20);
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int t;
        t        = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic clr_stats();
        n_out     = 0;
        last_mask = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[13];
        logic [5:0]  la;
        logic [31:0] oe;
        vt[0]  = '{16'h0000, 6'd0,  1'b0};
        vt[1]  = '{16'hFFF8, 6'd1,  1'b0};
        vt[2]  = '{16'hFFF0, 6'd2,  1'b0};
        vt[3]  = '{16'h0005, 6'd0,  1'b1};
        vt[4]  = '{16'hFFF9, 6'd0,  1'b0};
        vt[5]  = '{16'hFFF7, 6'd1,  1'b0};
        vt[6]  = '{16'hFF00, 6'd32, 1'b0};
        vt[7]  = '{16'hFE08, 6'd63, 1'b0};
        vt[8]  = '{16'hFE01, 6'd63, 1'b0};
        vt[9]  = '{16'hFE00, 6'd63, 1'b1};
        vt[10] = '{16'hFDF8, 6'd63, 1'b1};
        vt[11] = '{16'h8000, 6'd63, 1'b1};
        vt[12] = '{16'h7FFF, 6'd0,  1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_lut_addr", 32'(lut_addr), 32'd0);
        chk("rst_out_exp", out_exp, 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        cfg_len = 8'd1;
        for (int i = 0; i < 13; i++) begin
            send(vt[i].x);
            in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_addr", 32'(lut_addr), 32'(vt[i].idx));
            chk("tbl_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_exp", out_exp, lut_fn(vt[i].idx));
            chk("tbl_sat", 32'(out_sat), 32'(vt[i].sat));
            @(posedge clk);
            #1;
        end
        drain();

        clr_stats();
        cfg_len = 8'd4;
        for (int i = 0; i < 10; i++) send(16'(-8 * i));
        drain();
        chk("b2b_count", 32'(n_out), 32'd10);
        chk("b2b_last", 32'(last_mask), 32'h0088);
        chk("b2b_span", 32'(last_cyc - first_cyc), 32'd9);

        clr_stats();
        send(16'(-40));
        send(16'(-80));
        send(16'(-120));
        out_ready = 1'b0;
        in_x      = 16'(-160);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                la = lut_addr;
                oe = out_exp;
            end
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_addr", 32'(lut_addr), 32'd15);
            chk("stall_exp", out_exp, lut_fn(6'd10));
            chk("stall_addr_hold", 32'(lut_addr), 32'(la));
            chk("stall_exp_hold", out_exp, oe);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(16'(-160));
        send(16'(-200));
        drain();
        chk("stall_count", 32'(n_out), 32'd5);

        cfg_len = 8'd4;
        send(16'(-8));
        send(16'(-16));
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_lut_addr", 32'(lut_addr), 32'd0);
        @(posedge clk);
        #1;
        clr_stats();
        for (int i = 0; i < 4; i++) send(16'(-24 * i));
        drain();
        chk("mrst_count", 32'(n_out), 32'd4);
        chk("mrst_last", 32'(last_mask), 32'h0008);

        clr_stats();
        cfg_len = 8'd0;
        for (int i = 0; i < 3; i++) send(16'(-100 * i));
        drain();
        chk("len0_last", 32'(last_mask), 32'h0007);

        clr_stats();
        cfg_len = 8'd3;
        send(16'(-1));
        cfg_len = 8'd5;
        send(16'(-300));
        send(16'(-600));
        for (int i = 0; i < 5; i++) send(16'(-50 * i));
        drain();
        chk("lenchg_count", 32'(n_out), 32'd8);
        chk("lenchg_last", 32'(last_mask), 32'h0084);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
